// File: rtl/counter_defs.sv
// counter_defs: shared direction encodings and sizing helper for the counter library
package counter_defs;
   localparam logic DIR_UP = 1'b1;
   localparam logic DIR_DOWN = 1'b0;
   // bits needed to hold 0..v-1, never less than one
   function automatic int clog2(input longint unsigned v);
      int r;
      longint unsigned x;
      r = 0;
      x = 1;
      while (x < v) begin
         x = x << 1;
         r++;
      end
      return (r < 1) ? 1 : r;
   endfunction
endpackage

// File: rtl/t_ff_vec.sv
// t_ff_vec: WIDTH-bit register of T flip-flops with synchronous active-high reset
module t_ff_vec #(
   parameter int WIDTH = 4,
   parameter int RESET_VAL = 0
) (
   input  logic             clk,
   input  logic [WIDTH-1:0] t,
   input  logic             reset,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qbar
);
   logic [WIDTH-1:0] q_q;
   // each stage toggles when its t bit is set
   always_ff @(posedge clk)
      if (reset) q_q <= WIDTH'(RESET_VAL);
      else q_q <= q_q ^ t;
   assign q = q_q;
   assign qbar = ~q_q;
endmodule

// File: rtl/t_ff_counter.sv
// t_ff_counter: up/down modulo counter with load, terminal count and wrap pulse
module t_ff_counter
   import counter_defs::*;
#(
   parameter int WIDTH = 4,
   parameter int MODULUS = 16,
   parameter int RESET_VAL = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qbar,
   output logic             tc,
   output logic             wrap
);
   localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);
   localparam bit FULL = (longint'(MODULUS) == (64'd1 << WIDTH));
   logic [WIDTH-1:0] n, t, ld_val, up_n, dn_n;
   logic wrap_d, wrap_q;
   // next count; full-range modulus relies on natural overflow, otherwise
   // out-of-range states are steered back to 0 (up) or MAX (down)
   always_comb begin
      ld_val = (din > MAX) ? MAX : din;
      up_n = (!FULL && q >= MAX) ? '0 : q + 1'b1;
      dn_n = (!FULL && (q == '0 || q > MAX)) ? MAX : q - 1'b1;
      n = load ? ld_val : en ? ((up == DIR_UP) ? up_n : dn_n) : q;
      t = q ^ n;
      tc = (up == DIR_UP) ? (q == MAX) : (q == '0);
      wrap_d = en && !load && tc;
   end
   t_ff_vec #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_reg (
      .clk(clk), .t(t), .reset(reset), .q(q), .qbar(qbar)
   );
   // one-cycle pulse after a wrap transition
   always_ff @(posedge clk)
      if (reset) wrap_q <= 1'b0;
      else wrap_q <= wrap_d;
   assign wrap = wrap_q;
endmodule

// File: tb/tb_t_ff_counter.sv
// tb_t_ff_counter: directed scoreboard bench over three counter configurations
module tb_t_ff_counter;
   logic clk = 1'b0;
   logic rst_a, rst_b, rst_c, en, up, load;
   logic [3:0] din;
   logic [3:0] q_a, qb_a, q_b, qb_b;
   logic [2:0] q_c, qb_c;
   logic tc_a, tc_b, tc_c, w_a, w_b, w_c;
   int checks = 0;
   int errors = 0;
   typedef struct { int d; int q; int w; int tc; } exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;

   t_ff_counter #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0)) dut_a (
      .clk(clk), .reset(rst_a), .en(en), .up(up), .load(load), .din(din),
      .q(q_a), .qbar(qb_a), .tc(tc_a), .wrap(w_a));
   t_ff_counter #(.WIDTH(4), .MODULUS(10), .RESET_VAL(3)) dut_b (
      .clk(clk), .reset(rst_b), .en(en), .up(up), .load(load), .din(din),
      .q(q_b), .qbar(qb_b), .tc(tc_b), .wrap(w_b));
   t_ff_counter #(.WIDTH(3), .MODULUS(8), .RESET_VAL(0)) dut_c (
      .clk(clk), .reset(rst_c), .en(en), .up(up), .load(load), .din(din[2:0]),
      .q(q_c), .qbar(qb_c), .tc(tc_c), .wrap(w_c));

   function automatic int get_q(int d);
      return d == 0 ? int'(q_a) : d == 1 ? int'(q_b) : int'(q_c);
   endfunction
   function automatic int get_qb(int d);
      return d == 0 ? int'(qb_a) : d == 1 ? int'(qb_b) : int'(qb_c);
   endfunction
   function automatic int get_tc(int d);
      return d == 0 ? int'(tc_a) : d == 1 ? int'(tc_b) : int'(tc_c);
   endfunction
   function automatic int get_w(int d);
      return d == 0 ? int'(w_a) : d == 1 ? int'(w_b) : int'(w_c);
   endfunction

   task automatic chk(string tag, int obs, int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic compare(exp_t e);
      int mod;
      mod = (e.d == 2) ? 8 : 10;
      chk($sformatf("q[%0d]", e.d), get_q(e.d), e.q);
      chk($sformatf("qbar[%0d]", e.d), get_qb(e.d), e.q ^ (e.d == 2 ? 7 : 15));
      chk($sformatf("wrap[%0d]", e.d), get_w(e.d), e.w);
      chk($sformatf("tc[%0d]", e.d), get_tc(e.d), e.tc);
      chk($sformatf("tc_model[%0d]", e.d), e.tc, (up ? (e.q == mod - 1) : (e.q == 0)) ? 1 : 0);
   endtask

   task automatic step(int d, logic e_i, logic u_i, logic l_i, int di,
                       logic ra, logic rb, logic rc, int eq, int ew, int etc);
      exp_t e;
      @(negedge clk);
      en = e_i; up = u_i; load = l_i; din = 4'(di);
      rst_a = ra; rst_b = rb; rst_c = rc;
      e.d = d; e.q = eq; e.w = ew; e.tc = etc;
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) chk("scoreboard_empty", 1, 0);
      else compare(sb.pop_front());
   endtask

   initial begin
      en = 0; up = 1; load = 0; din = 0;
      rst_a = 1; rst_b = 1; rst_c = 1;
      // reset held two cycles
      step(0, 0, 1, 0, 0, 1, 1, 1, 0, 0, 0);
      step(0, 0, 1, 0, 0, 1, 1, 1, 0, 0, 0);
      chk("reset_b", int'(q_b), 3);
      chk("reset_c", int'(q_c), 0);
      // up-count 1..9,0,1 with wrap after 9->0
      for (int i = 1; i <= 11; i++) begin
         int v;
         v = i % 10;
         step(0, 1, 1, 0, 0, 0, 1, 1, v, (i == 10) ? 1 : 0, (v == 9) ? 1 : 0);
      end
      // down to 0, then 9,8,7 with wrap after 0->9
      step(0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 1);
      step(0, 1, 0, 0, 0, 0, 1, 1, 9, 1, 0);
      step(0, 1, 0, 0, 0, 0, 1, 1, 8, 0, 0);
      step(0, 1, 0, 0, 0, 0, 1, 1, 7, 0, 0);
      // loads: plain, saturating, load with en at terminal count
      step(0, 0, 1, 1, 7, 0, 1, 1, 7, 0, 0);
      step(0, 0, 1, 1, 13, 0, 1, 1, 9, 0, 1);
      step(0, 1, 1, 1, 9, 0, 1, 1, 9, 0, 1);
      // tc follows up combinationally at q=9
      @(negedge clk); en = 0; load = 0; up = 0; #1;
      chk("tc_comb_down_at9", int'(tc_a), 0);
      up = 1; #1;
      chk("tc_comb_up_at9", int'(tc_a), 1);
      // enable hold at 5 with up toggling
      step(0, 0, 1, 1, 5, 0, 1, 1, 5, 0, 0);
      for (int i = 0; i < 4; i++) step(0, 0, logic'(i % 2), 0, 0, 0, 1, 1, 5, 0, 0);
      // reset mid-operation on the RESET_VAL=3 instance
      step(1, 0, 1, 1, 7, 0, 0, 1, 7, 0, 0);
      step(1, 1, 1, 0, 0, 0, 0, 1, 8, 0, 0);
      step(1, 1, 1, 1, 2, 0, 1, 1, 3, 0, 0);
      step(1, 1, 1, 0, 0, 0, 0, 1, 4, 0, 0);
      step(1, 1, 1, 0, 0, 0, 0, 1, 5, 0, 0);
      // full-range modulus 8
      step(2, 0, 1, 1, 6, 0, 0, 0, 6, 0, 0);
      step(2, 1, 1, 0, 0, 0, 0, 0, 7, 0, 1);
      step(2, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0);
      step(2, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0);
      step(2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      step(2, 1, 0, 0, 0, 0, 0, 0, 7, 1, 0);
      step(2, 0, 0, 0, 0, 0, 0, 0, 7, 0, 0);
      chk("scoreboard_drained", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
